aes_enc_stream_ctrl: RTL and testbench

Upstream feeder and downstream drainer for the aes core's encrypt path.
- Accepts a 128-bit key plus a word-wide plaintext stream.
- Performs the core's key-init handshake and packs words into 128-bit blocks.
- Issues one next-block pulse per block, captures output_block_enc, and re-serialises the ciphertext as a word stream.
- Sits between the system DMA/stream fabric and aes.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_core_hs.sv | 45 ++++
 rtl/aes_enc_stream_ctrl.sv | 165 ++++++++++++++++
 tb/tb_aes_enc_stream_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES encrypt stream controller.
//   AES_BLOCK_W / AES_KEY_W : fixed AES-128 block and key widths
//   aes_block_t             : one 128-bit block
//   ctrl_state_t            : controller FSM states
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_KEY_W   = 128;

   typedef logic [AES_BLOCK_W-1:0] aes_block_t;

   typedef enum logic [3:0] {
      ST_NO_KEY  = 4'd0,
      ST_KEY_REQ = 4'd1,
      ST_KEY_LO  = 4'd2,
      ST_KEY_HI  = 4'd3,
      ST_COLLECT = 4'd4,
      ST_START   = 4'd5,
      ST_BLK_LO  = 4'd6,
      ST_BLK_HI  = 4'd7,
      ST_DRAIN   = 4'd8
   } ctrl_state_t;

endpackage

// File: rtl/aes_core_hs.sv
// Pulse / wait-low / wait-high handshake helper for one aes core operation.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : begin an operation (pulse appears the following cycle)
//   i_ready        : core ready flag
//   o_pulse        : one-cycle request pulse to the core
//   o_lo           : ready seen low after the pulse (operation has started)
//   o_done         : ready seen high again after the low phase
module aes_core_hs (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_start,
   input  logic i_ready,
   output logic o_pulse,
   output logic o_lo,
   output logic o_done
);

   localparam logic [1:0] PH_IDLE  = 2'd0;
   localparam logic [1:0] PH_PULSE = 2'd1;
   localparam logic [1:0] PH_WLO   = 2'd2;
   localparam logic [1:0] PH_WHI   = 2'd3;

   logic [1:0] r_ph;

   // Ready is ignored during the pulse cycle and until it has been seen low,
   // so a stale high left over from the previous operation never completes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ph <= PH_IDLE;
      end else begin
         case (r_ph)
            PH_IDLE:  if (i_start)  r_ph <= PH_PULSE;
            PH_PULSE: r_ph <= PH_WLO;
            PH_WLO:   if (!i_ready) r_ph <= PH_WHI;
            PH_WHI:   if (i_ready)  r_ph <= PH_IDLE;
            default:  r_ph <= PH_IDLE;
         endcase
      end
   end

   assign o_pulse = (r_ph == PH_PULSE);
   assign o_lo    = (r_ph == PH_WLO) && !i_ready;
   assign o_done  = (r_ph == PH_WHI) && i_ready;

endmodule

// File: rtl/aes_enc_stream_ctrl.sv
// Stream front/back end for the aes core encrypt path.
// Keys the core, packs DATA_W plaintext words into 128-bit blocks (first word
// in the MSBs), runs one block through the core at a time, and re-serialises
// the ciphertext in the same word order.
//   aclk, aresetn                      : clock, async active-low reset
//   cfg_key, cfg_key_load, key_valid   : key configuration
//   s_tdata/s_tvalid/s_tready          : plaintext word stream in
//   m_tdata/m_tvalid/m_tready          : ciphertext word stream out
//   key_enc, key_init_enc, key_ready_enc            : core key interface
//   input_block_enc, next_block_enc,
//   output_block_enc, block_ready_enc               : core block interface
//   blocks_done                        : count of fully drained blocks
module aes_enc_stream_ctrl
   import aes_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [AES_KEY_W-1:0]  cfg_key,
   input  logic                  cfg_key_load,
   output logic                  key_valid,
   input  logic [DATA_W-1:0]     s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [DATA_W-1:0]     m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [AES_KEY_W-1:0]  key_enc,
   output logic                  key_init_enc,
   input  logic                  key_ready_enc,
   output logic [AES_BLOCK_W-1:0] input_block_enc,
   output logic                  next_block_enc,
   input  logic [AES_BLOCK_W-1:0] output_block_enc,
   input  logic                  block_ready_enc,
   output logic [31:0]           blocks_done
);

   localparam int WORDS = AES_BLOCK_W / DATA_W;
   localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   ctrl_state_t          r_state, w_nxt;
   logic [CW-1:0]        r_cnt;
   aes_block_t           r_in, r_hold;
   logic [AES_KEY_W-1:0] r_key, r_pend_key;
   logic                 r_pend, r_kvalid;
   logic [31:0]          r_done;

   logic w_last, w_cnt0, w_kreq, w_s_hs, w_m_hs;
   logic w_key_lo, w_key_done, w_blk_lo, w_blk_done;

   assign w_last = (r_cnt == CW'(WORDS-1));
   assign w_cnt0 = (r_cnt == '0);
   // A fresh load in this cycle counts as pending so it is never lost.
   assign w_kreq = cfg_key_load | r_pend;

   // A rekey at a block boundary takes priority over starting a new block.
   assign s_tready = (r_state == ST_COLLECT) && !(w_cnt0 && w_kreq);
   assign m_tvalid = (r_state == ST_DRAIN);
   assign w_s_hs   = s_tvalid && s_tready;
   assign w_m_hs   = m_tvalid && m_tready;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_NO_KEY:  if (cfg_key_load) w_nxt = ST_KEY_REQ;
         ST_KEY_REQ: w_nxt = ST_KEY_LO;
         ST_KEY_LO:  if (w_key_lo) w_nxt = ST_KEY_HI;
         ST_KEY_HI:  if (w_key_done) w_nxt = ST_COLLECT;
         ST_COLLECT: begin
            if (w_cnt0 && w_kreq)      w_nxt = ST_KEY_REQ;
            else if (w_s_hs && w_last) w_nxt = ST_START;
         end
         ST_START:   w_nxt = ST_BLK_LO;
         ST_BLK_LO:  if (w_blk_lo) w_nxt = ST_BLK_HI;
         ST_BLK_HI:  if (w_blk_done) w_nxt = ST_DRAIN;
         ST_DRAIN:   if (w_m_hs && w_last) w_nxt = w_kreq ? ST_KEY_REQ : ST_COLLECT;
         default:    w_nxt = ST_NO_KEY;
      endcase
   end

   // Helpers launch on the state transition so their pulse phase lines up
   // with KEY_REQ / START.
   aes_core_hs u_key_hs (
      .i_clk   (aclk),
      .i_rst_n (aresetn),
      .i_start (w_nxt == ST_KEY_REQ),
      .i_ready (key_ready_enc),
      .o_pulse (key_init_enc),
      .o_lo    (w_key_lo),
      .o_done  (w_key_done)
   );

   aes_core_hs u_blk_hs (
      .i_clk   (aclk),
      .i_rst_n (aresetn),
      .i_start (w_nxt == ST_START),
      .i_ready (block_ready_enc),
      .o_pulse (next_block_enc),
      .o_lo    (w_blk_lo),
      .o_done  (w_blk_done)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= ST_NO_KEY;
         r_cnt      <= '0;
         r_in       <= '0;
         r_hold     <= '0;
         r_key      <= '0;
         r_pend_key <= '0;
         r_pend     <= 1'b0;
         r_kvalid   <= 1'b0;
         r_done     <= '0;
      end else begin
         r_state <= w_nxt;

         // Key path: direct load when unkeyed, otherwise park in the pending
         // register until a block boundary applies it.
         if (r_state == ST_NO_KEY) begin
            if (cfg_key_load) r_key <= cfg_key;
         end else if (w_nxt == ST_KEY_REQ) begin
            r_key    <= cfg_key_load ? cfg_key : r_pend_key;
            r_pend   <= 1'b0;
            r_kvalid <= 1'b0;
         end else if (cfg_key_load) begin
            r_pend     <= 1'b1;
            r_pend_key <= cfg_key;
         end

         case (r_state)
            ST_KEY_HI: if (w_key_done) begin
               r_kvalid <= 1'b1;
               r_cnt    <= '0;
            end
            ST_COLLECT: if (w_s_hs) begin
               for (int k = 0; k < WORDS; k++)
                  if (r_cnt == CW'(k)) r_in[(WORDS-1-k)*DATA_W +: DATA_W] <= s_tdata;
               r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
            ST_BLK_HI: if (w_blk_done) begin
               r_hold <= output_block_enc;
               r_cnt  <= '0;
            end
            ST_DRAIN: if (w_m_hs) begin
               r_cnt <= w_last ? '0 : r_cnt + CW'(1);
               if (w_last) r_done <= r_done + 32'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      m_tdata = '0;
      for (int k = 0; k < WORDS; k++)
         if (r_cnt == CW'(k)) m_tdata = r_hold[(WORDS-1-k)*DATA_W +: DATA_W];
   end

   assign key_valid       = r_kvalid;
   assign key_enc         = r_key;
   assign input_block_enc = r_in;
   assign blocks_done     = r_done;

endmodule

// File: tb/tb_aes_enc_stream_ctrl.sv
module tb_aes_enc_stream_ctrl;

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] C1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] C2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
   localparam logic [127:0] P3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
   localparam logic [127:0] C3 = 128'h43b1cd7f598ece23881b00e3ed030688;
   localparam logic [127:0] P4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
   localparam logic [127:0] C4 = 128'h7b0c785e27e8ad3f8223207104725dd4;
   localparam logic [127:0] P5 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C5 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic [127:0] cfg_key = '0;
   logic cfg_key_load = 1'b0;
   logic key_valid;
   logic [31:0] s_tdata = '0;
   logic s_tvalid = 1'b0;
   logic s_tready;
   logic [31:0] m_tdata;
   logic m_tvalid;
   logic m_tready = 1'b0;
   logic [127:0] key_enc;
   logic key_init_enc;
   logic key_ready_enc;
   logic [127:0] input_block_enc;
   logic next_block_enc;
   logic [127:0] output_block_enc;
   logic block_ready_enc;
   logic [31:0] blocks_done;

   int checks = 0;
   int errs = 0;

   always #5 aclk = ~aclk;

   aes_enc_stream_ctrl #(.DATA_W(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cfg_key(cfg_key), .cfg_key_load(cfg_key_load), .key_valid(key_valid),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .key_enc(key_enc), .key_init_enc(key_init_enc), .key_ready_enc(key_ready_enc),
      .input_block_enc(input_block_enc), .next_block_enc(next_block_enc),
      .output_block_enc(output_block_enc), .block_ready_enc(block_ready_enc),
      .blocks_done(blocks_done)
   );

   // Core stub: known-answer lookup keyed by the key latched at key_init time.
   function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
      if (k == K1 && p == P1) return C1;
      if (k == K1 && p == P2) return C2;
      if (k == K1 && p == P3) return C3;
      if (k == K1 && p == P4) return C4;
      if (k == K2 && p == P5) return C5;
      return 128'h0bad0bad0bad0bad0bad0bad0bad0bad;
   endfunction

   logic [127:0] core_key, core_in;
   int kc, bc;

   // Ready stays high (stale) two cycles after a pulse, low for three, then high.
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         key_ready_enc <= 1'b1; block_ready_enc <= 1'b1;
         kc <= 0; bc <= 0; core_key <= '0; core_in <= '0; output_block_enc <= '0;
      end else begin
         if (key_init_enc) begin
            core_key <= key_enc; kc <= 1;
         end else if (kc != 0) begin
            if (kc == 2) key_ready_enc <= 1'b0;
            if (kc == 5) begin key_ready_enc <= 1'b1; kc <= 0; end
            else kc <= kc + 1;
         end
         if (next_block_enc) begin
            core_in <= input_block_enc; bc <= 1;
         end else if (bc != 0) begin
            if (bc == 2) block_ready_enc <= 1'b0;
            if (bc == 5) begin
               block_ready_enc <= 1'b1; output_block_enc <= aes_ref(core_key, core_in); bc <= 0;
            end else bc <= bc + 1;
         end
      end
   end

   int cyc = 0, n_kinit = 0, n_nb = 0, br_rise_cyc = 0, mv_cyc = 0;
   logic prev_br = 1'b0, prev_mv = 1'b0;

   always @(negedge aclk) begin
      cyc <= cyc + 1;
      if (key_init_enc) n_kinit <= n_kinit + 1;
      if (next_block_enc) n_nb <= n_nb + 1;
      if (block_ready_enc && !prev_br) br_rise_cyc <= cyc;
      if (m_tvalid && !prev_mv) mv_cyc <= cyc;
      prev_br <= block_ready_enc;
      prev_mv <= m_tvalid;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic load_key(input logic [127:0] k);
      int n;
      @(posedge aclk); #1;
      cfg_key = k; cfg_key_load = 1'b1;
      @(posedge aclk); #1;
      cfg_key_load = 1'b0;
      n = 0;
      while (!key_valid && n < 100) begin @(posedge aclk); #1; n++; end
      if (!key_valid) begin checks++; errs++; $display("FAIL load_key timeout: key_valid=%b required 1", key_valid); end
   endtask

   task automatic send_word(input logic [31:0] d);
      int n;
      logic acc;
      s_tdata = d; s_tvalid = 1'b1; acc = 1'b0; n = 0;
      while (!acc && n < 200) begin
         @(negedge aclk); acc = s_tready;
         @(posedge aclk); #1; n++;
      end
      s_tvalid = 1'b0;
      if (!acc) begin checks++; errs++; $display("FAIL send_word timeout on %h: s_tready=0 required 1", d); end
   endtask

   // Last input word handshake must be followed by next_block_enc in the next cycle.
   task automatic send_block(input logic [127:0] b);
      send_word(b[127:96]); send_word(b[95:64]); send_word(b[63:32]); send_word(b[31:0]);
      @(negedge aclk);
      checks++;
      if (next_block_enc !== 1'b1) begin errs++; $display("FAIL next_block_latency: got %b required 1", next_block_enc); end
   endtask

   task automatic recv_block(input logic [127:0] exp, input int stall_at, input string nm);
      logic [127:0] got;
      logic [31:0] d0;
      int n;
      got = '0;
      @(posedge aclk); #1;
      m_tready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == stall_at) begin
            m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hffffffff;
            @(negedge aclk);
            d0 = m_tdata;
            for (int c = 0; c < 10; c++) begin
               @(negedge aclk);
               checks++;
               if ({m_tvalid, s_tready, m_tdata} !== {1'b1, 1'b0, d0}) begin
                  errs++;
                  $display("FAIL stall_hold cyc %0d: tvalid=%b sready=%b tdata=%h required 1 0 %h",
                           c, m_tvalid, s_tready, m_tdata, d0);
               end
            end
            @(posedge aclk); #1;
            s_tvalid = 1'b0; m_tready = 1'b1;
         end
         n = 0;
         do begin @(negedge aclk); n++; end while (!m_tvalid && n < 100);
         if (!m_tvalid) begin checks++; errs++; $display("FAIL %s drain timeout at word %0d", nm, k); end
         got = {got[95:0], m_tdata};
         @(posedge aclk); #1;
      end
      m_tready = 1'b0;
      checks++;
      if (got !== exp) begin errs++; $display("FAIL %s ciphertext: got %h required %h", nm, got, exp); end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      checks++;
      if ({key_valid, s_tready, m_tvalid, key_init_enc, next_block_enc} !== 5'b0) begin
         errs++; $display("FAIL reset_ctrl: got %b required 00000",
                          {key_valid, s_tready, m_tvalid, key_init_enc, next_block_enc});
      end
      checks++;
      if ({key_enc, input_block_enc, m_tdata, blocks_done} !== '0) begin
         errs++; $display("FAIL reset_data: key %h blk %h tdata %h done %0d required all 0",
                          key_enc, input_block_enc, m_tdata, blocks_done);
      end
      @(posedge aclk); #1;
      aresetn = 1'b1;
   endtask

   task automatic test_no_key();
      int nrdy;
      nrdy = 0;
      s_tvalid = 1'b1; s_tdata = 32'h12345678;
      repeat (20) begin @(negedge aclk); if (s_tready) nrdy++; end
      s_tvalid = 1'b0;
      checks++;
      if (nrdy != 0) begin errs++; $display("FAIL no_key_tready: s_tready high %0d cycles required 0", nrdy); end
      checks++;
      if (n_nb != 0) begin errs++; $display("FAIL no_key_pulse: next_block pulses %0d required 0", n_nb); end
   endtask

   task automatic test_basic();
      load_key(K1);
      checks++;
      if (key_enc !== K1) begin errs++; $display("FAIL basic_key_enc: got %h required %h", key_enc, K1); end
      send_block(P1);
      recv_block(C1, -1, "basic");
      checks++;
      if (blocks_done !== 32'd1) begin errs++; $display("FAIL basic_blocks_done: got %0d required 1", blocks_done); end
      checks++;
      if (mv_cyc - br_rise_cyc != 1) begin
         errs++; $display("FAIL drain_latency: got %0d cycles required 1", mv_cyc - br_rise_cyc);
      end
   endtask

   task automatic test_back_to_back();
      send_block(P2); recv_block(C2, -1, "b2b_2");
      send_block(P3); recv_block(C3, -1, "b2b_3");
      send_block(P4); recv_block(C4, -1, "b2b_4");
      checks++;
      if (blocks_done !== 32'd4) begin errs++; $display("FAIL b2b_blocks_done: got %0d required 4", blocks_done); end
      checks++;
      if (n_kinit != 1) begin errs++; $display("FAIL b2b_key_init: got %0d pulses required 1", n_kinit); end
   endtask

   task automatic test_stall();
      send_block(P1);
      recv_block(C1, 2, "stall");
      checks++;
      if (blocks_done !== 32'd5) begin errs++; $display("FAIL stall_blocks_done: got %0d required 5", blocks_done); end
   endtask

   task automatic test_key_change();
      send_word(P1[127:96]); send_word(P1[95:64]);
      cfg_key = K2; cfg_key_load = 1'b1;
      @(posedge aclk); #1;
      cfg_key_load = 1'b0;
      checks++;
      if (key_valid !== 1'b1) begin errs++; $display("FAIL keychg_valid_held: got %b required 1", key_valid); end
      send_word(P1[63:32]); send_word(P1[31:0]);
      recv_block(C1, -1, "keychg_old");
      send_block(P5);
      checks++;
      if (key_enc !== K2) begin errs++; $display("FAIL keychg_key_enc: got %h required %h", key_enc, K2); end
      recv_block(C5, -1, "keychg_new");
      checks++;
      if (n_kinit != 2) begin errs++; $display("FAIL keychg_key_init: got %0d pulses required 2", n_kinit); end
      checks++;
      if (blocks_done !== 32'd7) begin errs++; $display("FAIL keychg_blocks_done: got %0d required 7", blocks_done); end
   endtask

   task automatic test_reset_mid();
      int n;
      load_key(K1);
      send_block(P1);
      n = 0;
      while (block_ready_enc && n < 50) begin @(negedge aclk); n++; end
      @(negedge aclk);
      aresetn = 1'b0;
      #1;
      checks++;
      if ({key_valid, s_tready, m_tvalid, key_init_enc, next_block_enc} !== 5'b0) begin
         errs++; $display("FAIL midreset_ctrl: got %b required 00000",
                          {key_valid, s_tready, m_tvalid, key_init_enc, next_block_enc});
      end
      checks++;
      if ({key_enc, input_block_enc, m_tdata, blocks_done} !== '0) begin
         errs++; $display("FAIL midreset_data: key %h blk %h tdata %h done %0d required all 0",
                          key_enc, input_block_enc, m_tdata, blocks_done);
      end
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      load_key(K1);
      send_block(P1);
      recv_block(C1, -1, "after_reset");
      checks++;
      if (blocks_done !== 32'd1) begin errs++; $display("FAIL after_reset_blocks_done: got %0d required 1", blocks_done); end
   endtask

   initial begin
      test_reset();
      test_no_key();
      test_basic();
      test_back_to_back();
      test_stall();
      test_key_change();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule
